// File: rtl/montgomery_mul_pipe_pkg.sv
// rtl/montgomery_mul_pipe_pkg.sv - Kyber defaults and Montgomery constant helpers
//
// Purpose: shared constants for the Montgomery multiplier and a constant
// function that derives -Q^-1 mod 2^r_bits, used to cross-check the
// QNEG_INV parameter at elaboration.
// Ports: none (package).
package montgomery_mul_pipe_pkg;

  localparam int KYBER_W        = 12;
  localparam int KYBER_Q        = 3329;
  localparam int KYBER_R_BITS   = 16;
  localparam int KYBER_QNEG_INV = 3327;

  function automatic longint unsigned radix_mask(input int r_bits);
    return (r_bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << r_bits) - 64'd1);
  endfunction

  // Newton iteration x <- x*(2 - q*x) doubles the number of correct low bits
  // each pass; starting from x=1 (valid mod 2 for odd q), six passes cover 64.
  function automatic longint unsigned qneg_inv(input longint unsigned q, input int r_bits);
    longint unsigned mask;
    longint unsigned x;
    mask = radix_mask(r_bits);
    x    = 64'd1;
    for (int i = 0; i < 6; i++) begin
      x = x * (64'd2 - q * x);
    end
    return (~x + 64'd1) & mask;
  endfunction

endpackage

// File: rtl/montgomery_mul_pipe_reduce.sv
// rtl/montgomery_mul_pipe_reduce.sv - Montgomery reduction stages S2..S4
//
// Purpose: takes the registered product T and produces T*R^-1 mod Q over
// three stages (m computation, (T+m*Q)>>R_BITS, conditional subtract).
// Owns the S2..S4 valid bits; data registers only load behind a valid
// stage so bubbles and flushes never disturb out_result.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   en               global advance (stall when low)
//   clr              flush: clears valid bits only
//   in_valid, in_t   S1 valid bit and product a*b (2W bits)
//   s2_valid, s3_valid  internal stage valids, exported for tag chain/busy
//   out_valid, out_result  S4 output
module montgomery_mul_pipe_reduce
  import montgomery_mul_pipe_pkg::*;
#(
  parameter int W        = KYBER_W,
  parameter int Q        = KYBER_Q,
  parameter int R_BITS   = KYBER_R_BITS,
  parameter int QNEG_INV = KYBER_QNEG_INV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [2*W-1:0]   in_t,
  output logic             s2_valid,
  output logic             s3_valid,
  output logic             out_valid,
  output logic [W-1:0]     out_result
);

  localparam int PW = 2 * W;
  // T < 2^(2W) <= 2^(R_BITS+W) and m*Q < 2^R_BITS*Q, so R_BITS+W+1 bits hold the sum.
  localparam int SW = R_BITS + W + 1;

  localparam logic [R_BITS-1:0] QNEG_INV_R = R_BITS'(QNEG_INV);
  localparam logic [SW-1:0]     Q_S        = SW'(Q);
  localparam logic [W:0]        Q_T        = (W + 1)'(Q);

  logic [PW-1:0]     s2_t;
  logic [R_BITS-1:0] s2_m;
  logic [W:0]        s3_t;

  logic [R_BITS-1:0] m_next;
  logic [W:0]        t_next;
  logic [W-1:0]      res_next;

  // m = (T mod R) * QNEG_INV mod R; the R_BITS-wide context does the mod.
  assign m_next   = R_BITS'(SW'(in_t)) * QNEG_INV_R;
  // T + m*Q is an exact multiple of R, so the shift drops only zeros.
  assign t_next   = (W + 1)'((SW'(s2_t) + SW'(s2_m) * Q_S) >> R_BITS);
  assign res_next = W'((s3_t >= Q_T) ? (s3_t - Q_T) : s3_t);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      out_valid  <= 1'b0;
      s2_t       <= '0;
      s2_m       <= '0;
      s3_t       <= '0;
      out_result <= '0;
    end else if (clr) begin
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      out_valid  <= 1'b0;
    end else if (en) begin
      s2_valid  <= in_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (in_valid) begin
        s2_t <= in_t;
        s2_m <= m_next;
      end
      if (s2_valid) s3_t       <= t_next;
      if (s3_valid) out_result <= res_next;
    end
  end

endmodule

// File: rtl/montgomery_mul_pipe.sv
// rtl/montgomery_mul_pipe.sv - 4-stage pipelined Montgomery modular multiplier
//
// Purpose: out_result = in_a*in_b*2^-R_BITS mod Q with valid/ready
// backpressure, tag passthrough and flush. Global-stall pipeline: every
// stage advances together when the output slot is empty or being taken.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   flush                        clears all in-flight operations
//   in_valid/in_ready            input handshake (in_ready combinational)
//   in_a, in_b, in_tag           operands (< Q) and sideband tag
//   out_valid/out_ready          output handshake
//   out_result, out_tag          result in [0, Q) and its tag
//   busy                         any stage holds a valid operation
module montgomery_mul_pipe
  import montgomery_mul_pipe_pkg::*;
#(
  parameter int W        = KYBER_W,
  parameter int Q        = KYBER_Q,
  parameter int R_BITS   = KYBER_R_BITS,
  parameter int QNEG_INV = KYBER_QNEG_INV,
  parameter int TAG_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = 2 * W;
  localparam longint unsigned RMASK = radix_mask(R_BITS);

  if (Q % 2 == 0) begin : g_err_q_even
    $error("montgomery_mul_pipe: Q must be odd");
  end
  if (Q >= (1 << W)) begin : g_err_q_wide
    $error("montgomery_mul_pipe: Q must be below 2^W");
  end
  if (R_BITS < W) begin : g_err_r_bits
    $error("montgomery_mul_pipe: R_BITS must be at least W");
  end
  if ((((64'(QNEG_INV) * 64'(Q)) + 64'd1) & RMASK) != 64'd0) begin : g_err_qneg
    $error("montgomery_mul_pipe: QNEG_INV*Q+1 is not 0 mod 2^R_BITS");
  end
  if ((64'(QNEG_INV) & RMASK) != qneg_inv(64'(Q), R_BITS)) begin : g_err_qneg_fn
    $error("montgomery_mul_pipe: QNEG_INV differs from computed -Q^-1");
  end

  logic             advance;
  logic             accept;
  logic             s1_valid;
  logic [PW-1:0]    s1_t;
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] s2_tag;
  logic [TAG_W-1:0] s3_tag;
  logic             s2_valid;
  logic             s3_valid;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign busy     = s1_valid || s2_valid || s3_valid || out_valid;

  // S1 product and the tag chain. Tags follow the same valid-gated loads as
  // the data so out_tag, like out_result, holds across bubbles and flushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      s3_tag   <= '0;
      out_tag  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_t   <= PW'(in_a) * PW'(in_b);
        s1_tag <= in_tag;
      end
      if (s1_valid) s2_tag  <= s1_tag;
      if (s2_valid) s3_tag  <= s2_tag;
      if (s3_valid) out_tag <= s3_tag;
    end
  end

  montgomery_mul_pipe_reduce #(
    .W        (W),
    .Q        (Q),
    .R_BITS   (R_BITS),
    .QNEG_INV (QNEG_INV)
  ) u_reduce (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (advance),
    .clr        (flush),
    .in_valid   (s1_valid),
    .in_t       (s1_t),
    .s2_valid   (s2_valid),
    .s3_valid   (s3_valid),
    .out_valid  (out_valid),
    .out_result (out_result)
  );

endmodule

// File: tb/tb_montgomery_mul_pipe.sv
// tb/tb_montgomery_mul_pipe.sv - self-checking bench for montgomery_mul_pipe
module tb_montgomery_mul_pipe;

  localparam int W        = 12;
  localparam int Q        = 3329;
  localparam int R_BITS   = 16;
  localparam int QNEG_INV = 3327;
  localparam int TAG_W    = 10;
  localparam longint RINV = 169;  // 2^-16 mod 3329

  typedef struct {
    int a;
    int b;
    int tag;
    int exp_res;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  montgomery_mul_pipe #(
    .W(W), .Q(Q), .R_BITS(R_BITS), .QNEG_INV(QNEG_INV), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int q_res[$];
  int q_tag[$];
  int last_res = 0;
  int last_tag = 0;
  bit hold_prev = 1'b0;
  int prev_res = 0;
  int prev_tag = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int golden(input int a, input int b);
    longint p;
    p = (longint'(a) * longint'(b)) % Q;
    return int'((p * RINV) % Q);
  endfunction

  // One cycle, entered just after a negedge: drive, sample pre-edge state,
  // score the output transfer and the input accept, then move to next negedge.
  task automatic step(input bit iv, input int a, input int b, input int tg,
                      input bit ordy, input bit track, output bit acc);
    bit exp_rdy;
    in_valid  = iv;
    in_a      = W'(a);
    in_b      = W'(b);
    in_tag    = TAG_W'(tg);
    out_ready = ordy;
    #1;
    exp_rdy = !out_valid || ordy;
    check("in_ready", int'(in_ready), int'(exp_rdy));
    if (hold_prev) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_result", int'(out_result), prev_res);
      check("stall_tag", int'(out_tag), prev_tag);
    end
    hold_prev = out_valid && !ordy;
    prev_res  = int'(out_result);
    prev_tag  = int'(out_tag);
    if (out_valid && ordy) begin
      if (q_res.size() == 0) begin
        check("unexpected_out", int'(out_valid), 0);
      end else begin
        last_res = q_res.pop_front();
        last_tag = q_tag.pop_front();
        check("stream_result", int'(out_result), last_res);
        check("stream_tag", int'(out_tag), last_tag);
      end
    end
    acc = iv && exp_rdy && !flush;
    if (acc && track) begin
      q_res.push_back(golden(a, b));
      q_tag.push_back(tg % (1 << TAG_W));
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   lat;
    bit   acc;
    int   idx;
    int   cyc;
    bit   ordy;
    int   ra;
    int   rb;

    vecs[0] = '{1, 1, 5, 169};
    vecs[1] = '{2285, 1234, 1, 1234};
    vecs[2] = '{0, 3328, 2, 0};
    vecs[3] = '{3328, 1, 3, 3160};
    vecs[4] = '{3328, 3328, 4, 169};
    vecs[5] = '{2285, 2285, 6, 2285};
    vecs[6] = '{1, 2285, 7, 1};

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_result", int'(out_result), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // directed vectors, one at a time, with latency
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_a     = W'(vecs[i].a);
      in_b     = W'(vecs[i].b);
      in_tag   = TAG_W'(vecs[i].tag);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      check("vec_latency", lat, 4);
      check("vec_result", int'(out_result), vecs[i].exp_res);
      check("vec_tag", int'(out_tag), vecs[i].tag);
    end
    @(negedge clk);

    // back-to-back random stream
    for (int i = 0; i < 512; i++) begin
      if (i >= 4) check("throughput_valid", int'(out_valid), 1);
      ra = int'($urandom_range(Q - 1, 0));
      rb = int'($urandom_range(Q - 1, 0));
      step(1'b1, ra, rb, i % 1024, 1'b1, 1'b1, acc);
    end
    repeat (8) step(1'b0, 0, 0, 0, 1'b1, 1'b1, acc);
    check("stream_drained", q_res.size(), 0);

    // backpressure: out_ready low for 7 cycles mid-stream
    idx = 0;
    cyc = 0;
    while (idx < 20 && cyc < 100) begin
      ordy = !(cyc >= 8 && cyc < 15);
      if (!ordy) check("stall_full", int'(out_valid), 1);
      ra = (idx * 173 + 11) % Q;
      rb = (idx * 941 + 3) % Q;
      step(1'b1, ra, rb, 100 + idx, ordy, 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    check("stall_all_accepted", idx, 20);
    repeat (8) step(1'b0, 0, 0, 0, 1'b1, 1'b1, acc);
    check("stall_drained", q_res.size(), 0);

    // flush with 3 ops in flight and a simultaneous input
    for (int k = 0; k < 3; k++) step(1'b1, 10 + k, 20 + k, 300 + k, 1'b1, 1'b0, acc);
    flush = 1'b1;
    step(1'b1, 99, 99, 399, 1'b1, 1'b0, acc);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", int'(busy), 0);
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_hold_result", int'(out_result), last_res);
    check("flush_hold_tag", int'(out_tag), last_tag);
    for (int k = 0; k < 8; k++) begin
      check("flush_no_emerge", int'(out_valid), 0);
      @(negedge clk);
    end

    // synchronous reset with the pipeline full
    for (int k = 0; k < 4; k++) step(1'b1, 5 + k, 7, 20 + k, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    check("prefill_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_result", int'(out_result), 0);
    check("midrst_out_tag", int'(out_tag), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_a     = W'(1);
    in_b     = W'(1);
    in_tag   = TAG_W'(9);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("postrst_latency", lat, 4);
    check("postrst_result", int'(out_result), 169);
    check("postrst_tag", int'(out_tag), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
